// File: rtl/instr_encoder.sv
// Instruction-word encoder with a one-entry valid/ready output register and program address counter.
// Optional build macro INSTR_ENC_CHECK_EN: drop reserved-class requests and pulse err instead of emitting a NOP.
module instr_encoder #(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_class,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [1:0]        req_alu,
  input  logic [15:0]       req_imm,
  input  logic              addr_clr,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              err
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state_reg, state_next;
  logic [31:0]       instr_reg;
  logic [ADDR_W-1:0] count_reg;
  logic [31:0]       word;
  logic              transfer;
  logic              accept;
  logic              drop;
  logic              load;

  assign instr_valid = (state_reg == FULL);
  assign instr       = instr_reg;
  assign instr_addr  = count_reg;
  assign transfer    = instr_valid && instr_ready;
  assign req_ready   = !instr_valid || instr_ready;
  assign accept      = req_valid && req_ready;

`ifdef INSTR_ENC_CHECK_EN
  logic err_reg;

  assign drop = accept && (req_class == 2'd3);
  assign err  = err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= drop;
    end
  end
`else
  assign drop = 1'b0;
  assign err  = 1'b0;
`endif

  // A dropped reserved request is accepted upstream but never reaches the output register.
  assign load = accept && !drop;

  always_comb begin
    word        = '0;
    word[25:21] = req_rs;
    word[20:16] = req_rt;
    case (req_class)
      2'd0: begin
        word[31:26] = 6'd5;
        word[15:11] = req_rd;
        case (req_alu)
          2'd0:    word[5:0] = 6'd32;
          2'd1:    word[5:0] = 6'd34;
          2'd2:    word[5:0] = 6'd36;
          default: word[5:0] = 6'd37;
        endcase
      end
      2'd1: begin
        word[31:26] = 6'd6;
        word[15:0]  = req_imm;
      end
      2'd2: begin
        word[31:26] = 6'd7;
        word[15:0]  = req_imm;
      end
      default: word = '0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (load) state_next = FULL;
      FULL:    if (transfer && !load) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
      instr_reg <= '0;
      count_reg <= START_ADDR;
    end else begin
      state_reg <= state_next;
      if (load) begin
        instr_reg <= word;
      end
      if (addr_clr) begin
        count_reg <= START_ADDR;
      end else if (transfer) begin
        count_reg <= count_reg + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected words, a negedge monitor pops on each transfer.
module tb_instr_encoder;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_class;
  logic [4:0]    req_rs;
  logic [4:0]    req_rt;
  logic [4:0]    req_rd;
  logic [1:0]    req_alu;
  logic [15:0]   req_imm;
  logic          addr_clr;
  logic [31:0]   instr;
  logic [AW-1:0] instr_addr;
  logic          instr_valid;
  logic          instr_ready;
  logic          err;

  int            n_vec = 0;
  int            n_bad = 0;
  logic [31:0]   exp_q[$];
  logic [AW-1:0] model_cnt = '0;

  instr_encoder #(.ADDR_W(AW), .START_ADDR(2'd0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_class(req_class), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_alu(req_alu), .req_imm(req_imm), .addr_clr(addr_clr),
    .instr(instr), .instr_addr(instr_addr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .err(err)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endfunction

  // Monitor: reference address counter plus in-order word scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_cnt = '0;
    end else begin
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_word: got 0x%08h @%0d, expected no word", instr, instr_addr);
        end else begin
          check("word", instr, exp_q.pop_front());
          check("word_addr", 32'(instr_addr), 32'(model_cnt));
        end
      end
      if (addr_clr) model_cnt = '0;
      else if (instr_valid && instr_ready) model_cnt = model_cnt + 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send(input logic [1:0] cls, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [1:0] alu, input logic [15:0] imm,
                      input bit emit, input logic [31:0] exp, output int waits);
    bit acc;
    acc = 1'b0;
    waits = 0;
    req_class = cls; req_rs = rs; req_rt = rt; req_rd = rd; req_alu = alu; req_imm = imm;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      waits++;
    end
    req_valid = 1'b0;
    if (!acc) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: got no req_ready in 20 cycles, expected acceptance");
    end else if (emit) begin
      exp_q.push_back(exp);
    end
  endtask

  initial begin
    int w1, w2, wx;
    rst = 1'b1; req_valid = 1'b0; req_class = '0; req_rs = '0; req_rt = '0; req_rd = '0;
    req_alu = '0; req_imm = '0; addr_clr = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    check("reset_instr", instr, 32'h0);
    check("reset_valid", 32'(instr_valid), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_addr", 32'(instr_addr), 32'd0);
    tick();
    rst = 1'b0;
    instr_ready = 1'b1;

    // ALU add, one-cycle latency
    send(2'd0, 5'd1, 5'd2, 5'd3, 2'd0, 16'h0, 1'b1, 32'h14221820, wx);
    @(negedge clk);
    check("latency_valid", 32'(instr_valid), 32'd1);
    tick();

    // load then store back-to-back
    send(2'd1, 5'd4, 5'd5, 5'd0, 2'd0, 16'h0010, 1'b1, 32'h18850010, w1);
    send(2'd2, 5'd0, 5'd7, 5'd0, 2'd0, 16'hFFFC, 1'b1, 32'h1C07FFFC, w2);
    check("b2b_waits", 32'(w1 + w2), 32'd0);
    tick();

    // OR held under backpressure at address 3
    instr_ready = 1'b0;
    send(2'd0, 5'd31, 5'd31, 5'd31, 2'd3, 16'h0, 1'b1, 32'h17FFF825, wx);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_instr", instr, 32'h17FFF825);
      check("hold_addr", 32'(instr_addr), 32'd3);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    instr_ready = 1'b1;
    tick();

    // fifth transfer wraps to address 0, then addr_clr coincides with a transfer
    send(2'd0, 5'd0, 5'd0, 5'd0, 2'd0, 16'h0, 1'b1, 32'h14000020, wx);
    send(2'd0, 5'd2, 5'd3, 5'd4, 2'd1, 16'h0, 1'b1, 32'h14432022, wx);
    addr_clr = 1'b1;
    tick();
    addr_clr = 1'b0;
    send(2'd0, 5'd5, 5'd6, 5'd7, 2'd2, 16'h0, 1'b1, 32'h14A63824, wx);
    tick();

    // addr_clr re-addresses a held word
    instr_ready = 1'b0;
    send(2'd0, 5'd1, 5'd1, 5'd1, 2'd3, 16'h0, 1'b1, 32'h14210825, wx);
    @(negedge clk);
    check("held_addr_before_clr", 32'(instr_addr), 32'd1);
    @(posedge clk);
    #1;
    addr_clr = 1'b1;
    tick();
    addr_clr = 1'b0;
    @(negedge clk);
    check("held_addr_after_clr", 32'(instr_addr), 32'd0);
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    tick();

    // reserved class
`ifdef INSTR_ENC_CHECK_EN
    send(2'd3, 5'd8, 5'd9, 5'd10, 2'd0, 16'h5555, 1'b0, 32'h0, wx);
    @(negedge clk);
    check("rsv_err", 32'(err), 32'd1);
    check("rsv_valid", 32'(instr_valid), 32'd0);
`else
    send(2'd3, 5'd8, 5'd9, 5'd10, 2'd0, 16'h5555, 1'b1, 32'h00000000, wx);
    @(negedge clk);
    check("rsv_err", 32'(err), 32'd0);
    check("rsv_valid", 32'(instr_valid), 32'd1);
`endif
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rsv_err_after", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    send(2'd0, 5'd9, 5'd10, 5'd11, 2'd0, 16'h0, 1'b1, 32'h152A5820, wx);
    tick();

    // asynchronous reset while FULL and stalled
    instr_ready = 1'b0;
    send(2'd2, 5'd3, 5'd4, 5'd0, 2'd0, 16'h1234, 1'b1, 32'h1C641234, wx);
    @(negedge clk);
    check("pre_rst_valid", 32'(instr_valid), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_addr", 32'(instr_addr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    instr_ready = 1'b1;
    send(2'd0, 5'd2, 5'd3, 5'd4, 2'd1, 16'h0, 1'b1, 32'h14432022, wx);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
